// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_bus_arbiter slice.
// Holds the FSM state enum, owner encodings, the reset value of the
// last-served pointer and the saturating watchdog-counter helper.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // 1 = master 1 was served last, so master 0 wins the first tie.
    localparam logic LAST_RST = 1'b1;

    localparam int CNT_W = 8;

    // Increment without wrapping; the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the slave bridge.
// modport slave  : the arbiter's view (it serves the masters, drives the bridge).
// modport master : the environment's view (masters and slave bridge model).
interface dm_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_be;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_be;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_be;
    logic          s_ack;
    logic [DW-1:0] s_rdata;

    logic [1:0]    owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_ack, m1_err, m1_rdata,
        output s_req, s_we, s_addr, s_wdata, s_be,
        input  s_ack, s_rdata,
        output owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_ack, m1_err, m1_rdata,
        input  s_req, s_we, s_addr, s_wdata, s_be,
        output s_ack, s_rdata,
        input  owner
    );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational winner select for dm_bus_arbiter.
// Build option DM_ARB_RR_EN: round-robin on ties (uses last-served pointer).
// Without it: fixed priority, master 0 wins every tie and no pointer exists.
module dm_arb_pick (
`ifdef DM_ARB_RR_EN
    input  logic last_m1,
`endif
    input  logic m0_req,
    input  logic m1_req,
    output logic any_req,
    output logic pick_m1
);

    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
        any_req = m0_req | m1_req;
`ifdef DM_ARB_RR_EN
        pick_m1 = m1_req & (~m0_req | ~last_m1);
`else
        pick_m1 = m1_req & ~m0_req;
`endif
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master / one-slave arbiter in front of the data-memory bridge.
// Master 0 is the CPU data port, master 1 the DMA engine. Each transfer is
// latched once, forwarded to the slave, and completed with a one-cycle
// ack, or a one-cycle err if the slave stays silent for TIMEOUT cycles.
// Build option DM_ARB_RR_EN selects round-robin tie-breaking (see dm_arb_pick).
module dm_bus_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    dm_bus_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       owner_q;
    logic             err_q;
    logic [DW-1:0]    rdata_q;
    logic             s_we_q;
    logic [AW-1:0]    s_addr_q;
    logic [DW-1:0]    s_wdata_q;
    logic [3:0]       s_be_q;

    logic             any_req;
    logic             pick_m1;
    logic             timeout_hit;
    logic             resp_m0;
    logic             resp_m1;

`ifdef DM_ARB_RR_EN
    logic             last_m1_q;
`endif

    dm_arb_pick u_pick (
`ifdef DM_ARB_RR_EN
        .last_m1 (last_m1_q),
`endif
        .m0_req  (bus.m0_req),
        .m1_req  (bus.m1_req),
        .any_req (any_req),
        .pick_m1 (pick_m1)
    );

    // Watchdog compares the registered count, so the error lands TIMEOUT+2
    // cycles after the request and a same-cycle s_ack still takes priority.
    assign timeout_hit = (cnt_q >= TO_CNT);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: grant in IDLE, wait for ack or timeout, one response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = XFER;
            XFER:    if (bus.s_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer latches, watchdog counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            owner_q   <= OWN_NONE;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (any_req) begin
                        owner_q   <= pick_m1 ? OWN_M1        : OWN_M0;
                        s_we_q    <= pick_m1 ? bus.m1_we     : bus.m0_we;
                        s_addr_q  <= pick_m1 ? bus.m1_addr   : bus.m0_addr;
                        s_wdata_q <= pick_m1 ? bus.m1_wdata  : bus.m0_wdata;
                        s_be_q    <= pick_m1 ? bus.m1_be     : bus.m0_be;
                    end
                end
                XFER: begin
                    if (bus.s_ack) begin
                        rdata_q <= bus.s_rdata;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                        if (timeout_hit) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    owner_q <= OWN_NONE;
                end
                default: begin
                    cnt_q   <= '0;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

`ifdef DM_ARB_RR_EN
    // Remember who was served so the other master wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  last_m1_q <= LAST_RST;
        else if (state_q == RESP) last_m1_q <= (owner_q == OWN_M1);
    end
`endif

    assign resp_m0 = (state_q == RESP) && (owner_q == OWN_M0);
    assign resp_m1 = (state_q == RESP) && (owner_q == OWN_M1);

    assign bus.s_req   = (state_q == XFER);
    assign bus.s_we    = s_we_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_be    = s_be_q;
    assign bus.owner   = owner_q;

    // Only the winner sees a response; the other master's outputs stay 0.
    assign bus.m0_ack   = resp_m0 & ~err_q;
    assign bus.m0_err   = resp_m0 &  err_q;
    assign bus.m0_rdata = resp_m0 ? rdata_q : '0;
    assign bus.m1_ack   = resp_m1 & ~err_q;
    assign bus.m1_err   = resp_m1 &  err_q;
    assign bus.m1_rdata = resp_m1 ? rdata_q : '0;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter. Cycle numbers in the scenarios count
// from the cycle in which the request is first visible to an idle arbiter.
// Expected arbitration order follows DM_ARB_RR_EN when it is defined.
module tb_dm_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

`ifdef DM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    dm_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic exp_m1;
        int   errs;
        int   err_at;

        rst = 1'b1;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        bus.s_ack = 0; bus.s_rdata = '0;

        // ---- reset state
        tick; tick;
        chk_eq("rst_s_req",    bus.s_req,    0);
        chk_eq("rst_owner",    bus.owner,    0);
        chk_eq("rst_s_addr",   bus.s_addr,   0);
        chk_eq("rst_s_be",     bus.s_be,     0);
        chk_eq("rst_m0_ack",   bus.m0_ack,   0);
        chk_eq("rst_m1_err",   bus.m1_err,   0);
        chk_eq("rst_m0_rdata", bus.m0_rdata, 0);

        // ---- single m0 read, two slave wait states
        rst = 1'b0;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_7F04; bus.m0_be = 4'hF;
        bus.s_rdata = 32'h1234_5678;
        chk_eq("rd_c0_s_req", bus.s_req, 0);
        tick; // cycle 1
        chk_eq("rd_c1_s_req",  bus.s_req,  1);
        chk_eq("rd_c1_owner",  bus.owner,  2'b01);
        chk_eq("rd_c1_s_addr", bus.s_addr, 32'h0000_7F04);
        tick; // cycle 2
        chk_eq("rd_c2_s_req",  bus.s_req,  1);
        tick; // cycle 3
        chk_eq("rd_c3_s_req",  bus.s_req,  1);
        chk_eq("rd_c3_ack",    bus.m0_ack, 0);
        bus.s_ack = 1;
        tick; // cycle 4
        chk_eq("rd_c4_s_req",  bus.s_req,    0);
        chk_eq("rd_c4_ack",    bus.m0_ack,   1);
        chk_eq("rd_c4_rdata",  bus.m0_rdata, 32'h1234_5678);
        chk_eq("rd_c4_owner",  bus.owner,    2'b01);
        chk_eq("rd_c4_m1_ack", bus.m1_ack,   0);
        bus.m0_req = 0; bus.s_ack = 0;
        tick; // cycle 5
        chk_eq("rd_c5_ack",   bus.m0_ack, 0);
        chk_eq("rd_c5_owner", bus.owner,  0);

        // ---- both masters request from reset release, six transfers
        rst = 1'b1;
        tick;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_0100;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_0200; bus.m1_be = 4'hF;
        bus.s_ack = 1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_m1 = RR_MODE && (i % 2 == 1);
            bus.s_rdata = 32'hA000_0000 + i;
            tick; // XFER
            chk_eq($sformatf("tie%0d_owner", i),  bus.owner,  exp_m1 ? 2'b10 : 2'b01);
            chk_eq($sformatf("tie%0d_s_addr", i), bus.s_addr, exp_m1 ? 32'h200 : 32'h100);
            tick; // RESP
            chk_eq($sformatf("tie%0d_m0_ack", i), bus.m0_ack, !exp_m1);
            chk_eq($sformatf("tie%0d_m1_ack", i), bus.m1_ack, exp_m1);
            chk_eq($sformatf("tie%0d_rdata", i),
                   exp_m1 ? bus.m1_rdata : bus.m0_rdata, 32'hA000_0000 + i);
            if (i == 5) begin
                bus.m0_req = 0;
                bus.m1_req = 0;
            end
            tick; // IDLE
        end
        bus.s_ack = 0;

        // ---- m1 byte write, fields changed after grant
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h0000_0013;
        bus.m1_be = 4'b1000; bus.m1_wdata = 32'hAB00_0000;
        tick; // cycle 1
        bus.m1_wdata = 32'hDEAD_BEEF; bus.m1_be = 4'hF; bus.m1_addr = '0;
        chk_eq("wr_c1_owner", bus.owner,   2'b10);
        chk_eq("wr_c1_we",    bus.s_we,    1);
        chk_eq("wr_c1_addr",  bus.s_addr,  32'h0000_0013);
        chk_eq("wr_c1_wdata", bus.s_wdata, 32'hAB00_0000);
        chk_eq("wr_c1_be",    bus.s_be,    4'b1000);
        tick; // cycle 2
        chk_eq("wr_c2_wdata", bus.s_wdata, 32'hAB00_0000);
        chk_eq("wr_c2_be",    bus.s_be,    4'b1000);
        bus.s_ack = 1;
        tick; // cycle 3
        chk_eq("wr_c3_m1_ack", bus.m1_ack, 1);
        chk_eq("wr_c3_m0_ack", bus.m0_ack, 0);
        chk_eq("wr_c3_m1_err", bus.m1_err, 0);
        bus.m1_req = 0; bus.s_ack = 0;
        tick;

        // ---- slave never answers: one err in cycle TIMEOUT+2
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h0000_7F80; bus.m0_be = 4'hF;
        bus.s_rdata = 32'hFFFF_FFFF;
        errs = 0; err_at = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick;
            if (bus.m0_err) begin
                errs++;
                err_at = cyc;
                chk_eq("to_ack_during_err", bus.m0_ack,   0);
                chk_eq("to_rdata_on_err",   bus.m0_rdata, 0);
            end
            if (cyc == TIMEOUT + 2) bus.m0_req = 0;
        end
        chk_eq("to_err_count", errs,   1);
        chk_eq("to_err_cycle", err_at, TIMEOUT + 2);
        chk_eq("to_idle_owner", bus.owner, 0);
        chk_eq("to_idle_s_req", bus.s_req, 0);

        // ---- next request after a timeout completes normally
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h0000_0040;
        bus.s_ack = 1; bus.s_rdata = 32'hCAFE_F00D;
        tick;
        chk_eq("post_to_owner", bus.owner, 2'b10);
        tick;
        chk_eq("post_to_ack",   bus.m1_ack,   1);
        chk_eq("post_to_rdata", bus.m1_rdata, 32'hCAFE_F00D);
        bus.m1_req = 0; bus.s_ack = 0;
        tick;

        // ---- s_ack arrives on the timeout cycle: ack wins
        bus.m0_req = 1; bus.m0_addr = 32'h0000_7F10; bus.s_rdata = 32'h600D_DA7A;
        tick; // cycle 1
        repeat (TIMEOUT) tick; // cycle TIMEOUT+1
        chk_eq("edge_still_xfer", bus.s_req, 1);
        bus.s_ack = 1;
        tick; // cycle TIMEOUT+2
        chk_eq("edge_ack",   bus.m0_ack,   1);
        chk_eq("edge_err",   bus.m0_err,   0);
        chk_eq("edge_rdata", bus.m0_rdata, 32'h600D_DA7A);
        bus.m0_req = 0; bus.s_ack = 0;
        tick;

        // ---- asynchronous reset during XFER
        bus.m0_req = 1; bus.m0_addr = 32'h0000_0080;
        tick; // cycle 1
        chk_eq("ar_xfer_s_req", bus.s_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("ar_s_req_drop", bus.s_req,  0);
        chk_eq("ar_no_ack",     bus.m0_ack, 0);
        chk_eq("ar_no_err",     bus.m0_err, 0);
        bus.m0_req = 0;
        tick;
        rst = 1'b0;
        tick;
        chk_eq("ar_owner", bus.owner, 0);
        chk_eq("ar_idle",  bus.s_req, 0);
        bus.m0_req = 1; bus.s_ack = 1; bus.s_rdata = 32'h0BAD_0001;
        tick;
        chk_eq("ar_regrant", bus.s_req, 1);
        tick;
        chk_eq("ar_reack",   bus.m0_ack,   1);
        chk_eq("ar_rerdata", bus.m0_rdata, 32'h0BAD_0001);
        bus.m0_req = 0; bus.s_ack = 0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
# dm_bus_arbiter

Two-master, one-slave arbiter placed in front of the data-memory/peripheral bridge. It shares the bus between the multicycle CPU data port (master 0) and a DMA engine (master 1). Each transfer is latched, forwarded to the slave and completed with a one-cycle acknowledge. A watchdog converts a hung slave access into an error response, so a missing peripheral at 0x7F00–0x7FFF cannot stall the CPU state machine forever.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, slave-wait cycles before error; legal range 1..255
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req, m1_req  in  1  transfer request; held until the matching ack/err
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_be, m1_be  in  4  byte enables (sb → one-hot, sw → 4'hF)
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  one-cycle timeout pulse (ack stays 0)
- m0_rdata, m1_rdata  out  DW  registered read data; valid during ack
- s_req  out  1  slave request
- s_we, s_addr, s_wdata, s_be  out  1/AW/DW/4  latched transfer fields
- s_ack  in  1  slave completion
- s_rdata  in  DW  slave read data; sampled when s_ack=1
- owner  out  2  2'b00 idle, 2'b01 m0, 2'b10 m1

## Operation
- States: IDLE, XFER, RESP.
- IDLE: if any request is pending, the picker selects a winner. The winner's we/addr/wdata/be are latched into s_* registers, owner is set, and the FSM goes to XFER. With no request it stays in IDLE.
- XFER: s_req=1 with the latched fields. The wait counter increments each cycle that s_ack=0.
  - s_ack=1: capture s_rdata and go to RESP with ok.
  - Counter reaches TIMEOUT with s_ack still 0: go to RESP with err.
  - s_ack on the same edge as the timeout: ack wins and no err is raised.
- RESP: s_req=0. Pulse the winner's ack (or err) for one cycle. rdata holds the captured value, or 0 on err. Clear the counter, update the last-served pointer, then go to IDLE.
- Masters must drop req in the cycle after ack/err unless they issue a new transfer. A req still high in IDLE counts as a new request.
- A non-winning master's req is ignored until the FSM is back in IDLE. Its outputs stay 0.
- Request fields are latched once per transfer, so masters may change them after grant. Write data is never re-sampled.

## Timing
- Reset values: state=IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, s_be=0, m*_ack=0, m*_err=0, m*_rdata=0, owner=0, counter=0, last-served=m1 (so m0 wins the first tie).
- Reset mid-transfer drops s_req immediately (asynchronous) with no ack/err. The master must re-request.
- Minimum latency, with req seen in cycle 0 and a zero-wait slave:
  - s_req in cycle 1;
  - s_ack in cycle 1;
  - ack in cycle 2;
  - next grant decided in cycle 3.
- Each slave wait cycle adds one cycle of latency.
- Error latency is TIMEOUT+2 cycles from req.
- Back-to-back throughput is one transfer every 3 cycles.
- Counter width is 8 bits and saturates; it never wraps.

## Configuration
- DM_ARB_RR_EN defined: round-robin. On a tie, the master not served last wins. A single requester always wins regardless of the pointer.
- Undefined: fixed priority, m0 always wins ties. The pointer register is removed.

## Structure
- Package dm_arb_pkg holds:
  - the state enum (IDLE/XFER/RESP);
  - owner encodings OWN_NONE/OWN_M0/OWN_M1;
  - the reset default for the last-served pointer.
- One sub-module, dm_arb_pick: a combinational winner select from (m0_req, m1_req, last-served). The DM_ARB_RR_EN variants live only here.
- The FSM, latches and watchdog stay in the top module.

## Test plan
- Single m0 read from 0x7F04 with 2 slave wait states, s_rdata=0x1234_5678 → s_req high for cycles 1–3, m0_ack in cycle 4 with m0_rdata=0x1234_5678, owner=01 during cycles 1–4.
- m0 and m1 both request at reset release (with DM_ARB_RR_EN) → m0 served first, then m1; repeating both → strict m0/m1 alternation over 6 transfers. Without the macro, m0 wins all 6.
- m1 write (sb: addr 0x0000_0013, be=4'b1000, wdata=0xAB00_0000), with m1 changing wdata after grant → s_wdata stays 0xAB00_0000 and s_be=4'b1000.
- Slave never acks, TIMEOUT=15 → m0_err pulses exactly once in cycle 17, m0_ack=0, m0_rdata=0; FSM returns to IDLE and serves the next request normally.
- s_ack asserted on the cycle the counter hits TIMEOUT → ack with data, no err.
- rst asserted while in XFER → s_req falls without waiting for clk, no ack/err. After release, state is IDLE and owner=0.
